// File: rtl/sint_varint_decoder.sv
// -----------------------------------------------------------------------------
// sint_varint_decoder
//
// Decodes one protobuf sint32/sint64 field from a stream of varint bytes.
// The bytes arrive least significant group first. The decoder undoes the
// zigzag mapping and presents the signed result sign-extended to 64 bits.
// It also flags varints that run past the byte limit for the field width.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   rst        : asynchronous reset, active high
//   in_valid   : in_byte holds a valid wire byte
//   in_byte    : bit 7 = continuation, bits 6:0 = payload group
//   in_ready   : decoder accepts in_byte this cycle (IDLE/ACCUM)
//   is_32      : 1 = sint32 field, 0 = sint64; sampled on the first byte
//   out_valid  : out_val/out_err hold a result (OUT state)
//   out_ready  : consumer accepts the result
//   out_val    : zigzag-decoded two's-complement value
//   out_err    : result is an overlong-varint error (out_val = 0)
// -----------------------------------------------------------------------------
module sint_varint_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        is_32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_val,
  output logic        out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is32_q, is32_d;
  logic [63:0] val_q, val_d;
  logic        err_q, err_d;

  // Transfer-time view of the varint: a byte taken in IDLE starts from a
  // clean accumulator, index 0 and the freshly sampled field width.
  logic        take;
  logic        first;
  logic [3:0]  idx;
  logic        mode32;
  logic [6:0]  shamt;
  logic [63:0] acc_new;
  logic [3:0]  last_idx;

  assign in_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign out_val   = val_q;
  assign out_err   = err_q;

  assign take     = in_valid && in_ready;
  assign first    = (state_q == S_IDLE);
  assign idx      = first ? 4'd0 : cnt_q;
  assign mode32   = first ? is_32 : is32_q;
  assign shamt    = 7'(idx) * 7'd7;
  // Payload bits shifted past bit 63 fall off the 64-bit result.
  assign acc_new  = (first ? 64'd0 : acc_q) | ({57'd0, in_byte[6:0]} << shamt);
  assign last_idx = mode32 ? 4'd4 : 4'd9;

  // Zigzag decode: (n >> 1) ^ -(n & 1). In 32-bit mode only n[31:0] is used.
  // The upper accumulator bits are dropped silently.
  function automatic logic [63:0] zigzag(input logic [63:0] n, input logic m32);
    logic [31:0] r32;
    logic [63:0] r64;
    r32 = {1'b0, n[31:1]} ^ {32{n[0]}};
    r64 = {1'b0, n[63:1]} ^ {64{n[0]}};
    return m32 ? {{32{r32[31]}}, r32} : r64;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    is32_d  = is32_q;
    val_d   = val_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (take) begin
          acc_d  = acc_new;
          cnt_d  = idx + 4'd1;
          is32_d = mode32;
          if (!in_byte[7]) begin
            state_d = S_OUT;
            val_d   = zigzag(acc_new, mode32);
            err_d   = 1'b0;
          end else if (idx == last_idx) begin
            // The last allowed byte still has a continuation bit: report an
            // error now and leave any remaining bytes for the next varint.
            state_d = S_OUT;
            val_d   = 64'd0;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 64'd0;
      cnt_q   <= 4'd0;
      is32_q  <= 1'b0;
      val_q   <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      is32_q  <= is32_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sint_varint_decoder.sv
// -----------------------------------------------------------------------------
// tb_sint_varint_decoder
//
// Directed bench for sint_varint_decoder. The expected results are queued in
// a scoreboard when a varint is driven, then popped when out_valid appears.
// -----------------------------------------------------------------------------
module tb_sint_varint_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        is_32;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_val;
  logic        out_err;

  typedef struct {
    logic [63:0] val;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] seq[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sint_varint_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .is_32     (is_32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the bytes in seq. Later bytes carry is_32 inverted when flip is set
  // to show that only the first byte's width is used. Gap idle cycles follow
  // every non-final byte. The task returns on the negedge after the last transfer.
  task automatic send_seq(input logic mode, input bit flip, input int gap);
    int n = seq.size();
    for (int i = 0; i < n; i++) begin
      int w = 0;
      in_valid = 1'b1;
      in_byte  = seq[i];
      is_32    = (i == 0) ? mode : (mode ^ flip);
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'hxx;
      is_32    = 1'bx;
      if (i != n - 1) repeat (gap) @(negedge clk);
    end
    seq.delete();
  endtask

  task automatic push_exp(input logic [63:0] v, input logic e);
    exp_t x;
    x.val = v;
    x.err = e;
    sb.push_back(x);
  endtask

  // Wait for a result, compare it with the scoreboard head, optionally hold
  // out_ready low for a while, then accept the result.
  task automatic expect_out(input string tag, input int hold, input bit lat1);
    int   waits = 0;
    exp_t x;
    while (!out_valid && waits < 30) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (lat1) check({tag, "_latency"}, 64'(waits), 64'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      x = sb.pop_front();
      check({tag, "_val"}, out_val, x.val);
      check({tag, "_err"}, {63'd0, out_err}, {63'd0, x.err});
      for (int i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_hold_val"}, out_val, x.val);
        check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_post_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  // Independent encoder: zigzag-encode v and emit it as varint bytes into seq.
  task automatic encode(input logic [63:0] v, input logic m32);
    logic [63:0] z;
    logic [7:0]  b;
    if (m32) z = {32'd0, (v[31:0] << 1) ^ {32{v[31]}}};
    else     z = (v << 1) ^ {64{v[63]}};
    do begin
      b = {1'b0, z[6:0]};
      z = z >> 7;
      if (z != 0) b[7] = 1'b1;
      seq.push_back(b);
    end while (z != 0);
  endtask

  initial begin
    logic [63:0] rv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    is_32     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_val", out_val, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // sint32 0x04 -> 2, result one cycle after the byte
    seq.push_back(8'h04);
    push_exp(64'h2, 1'b0);
    send_seq(1'b1, 1'b0, 0);
    expect_out("s32_two", 0, 1'b1);

    // sint64 0x03 -> -2
    seq.push_back(8'h03);
    push_exp(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    send_seq(1'b0, 1'b0, 0);
    expect_out("s64_m2", 0, 1'b1);

    // sint64 0xFE 0x01 -> 127, with idle gaps between bytes
    seq = '{8'hFE, 8'h01};
    push_exp(64'h7F, 1'b0);
    send_seq(1'b0, 1'b0, 3);
    expect_out("s64_127_gap", 0, 1'b1);

    // sint64 minimum: 0xFF x9, 0x01 -> 0x8000000000000000
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_exp(64'h8000_0000_0000_0000, 1'b0);
    send_seq(1'b0, 1'b0, 0);
    expect_out("s64_min", 0, 1'b1);

    // sint32 minimum with is_32 flipped on later bytes (must be ignored)
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    push_exp(64'hFFFF_FFFF_8000_0000, 1'b0);
    send_seq(1'b1, 1'b1, 0);
    expect_out("s32_min", 0, 1'b1);

    // sint32 with upper payload bits: 0xFF x4, 0x7F -> high bits dropped -> min
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    push_exp(64'hFFFF_FFFF_8000_0000, 1'b0);
    send_seq(1'b1, 1'b0, 0);
    expect_out("s32_trunc", 0, 1'b1);

    // Overlong sint32: 0x80 x5 -> error, held for two cycles, then 0x02 -> 1
    seq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    push_exp(64'd0, 1'b1);
    send_seq(1'b1, 1'b0, 0);
    expect_out("s32_overlong", 2, 1'b1);
    seq.push_back(8'h02);
    push_exp(64'd1, 1'b0);
    send_seq(1'b1, 1'b0, 0);
    expect_out("after_overlong", 0, 1'b1);

    // Overlong sint64: ten bytes with continuation set
    seq = '{8'h81, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    push_exp(64'd0, 1'b1);
    send_seq(1'b0, 1'b0, 0);
    expect_out("s64_overlong", 0, 1'b1);

    // Backpressure: out_ready low for three cycles
    seq = '{8'hAC, 8'h02};
    push_exp(64'd150, 1'b0);
    send_seq(1'b0, 1'b0, 0);
    expect_out("backpressure", 3, 1'b1);

    // Reset in the middle of a varint: no output for the aborted bytes
    seq = '{8'h80, 8'h80};
    send_seq(1'b0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid_in_rst", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_valid_after", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    seq.push_back(8'h01);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_seq(1'b0, 1'b0, 0);
    expect_out("midrst_next", 0, 1'b1);

    // Random round trips through the independent encoder
    for (int i = 0; i < 6; i++) begin
      logic m;
      m  = i[0];
      rv = {$urandom(), $urandom()};
      if (m) rv = {{32{rv[31]}}, rv[31:0]};
      encode(rv, m);
      push_exp(rv, 1'b0);
      send_seq(m, 1'b0, i % 2);
      expect_out("random", i % 3, 1'b1);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sint_varint_decoder.md
SINT_VARINT_DECODER -- requirements
Module: sint_varint_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: in_byte holds a valid wire byte.
REQ-004 SHALL have port in_byte, input, 8 bits: varint byte; bit 7 is continuation, bits 6:0 are payload (LSB group first).
REQ-005 SHALL have port in_ready, output, 1 bit: decoder accepts in_byte this cycle.
REQ-006 SHALL have port is_32, input, 1 bit: 1 = sint32 field, 0 = sint64 field; sampled on the first byte of a varint.
REQ-007 SHALL have port out_valid, output, 1 bit: out_val/out_err hold a result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port out_val, output, 64 bits: zigzag-decoded signed value (two's complement).
REQ-010 SHALL have port out_err, output, 1 bit: result is an overlong-varint error; valid only with out_valid.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE (no bytes taken), ACCUM (at least one byte taken, last byte had bit 7 = 1), OUT (result held).
REQ-012 SHALL transfer an input byte only when in_valid && in_ready, and a result only when out_valid && out_ready.
REQ-013 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in OUT.
REQ-014 SHALL drive out_valid = 1 only in OUT.
REQ-015 SHALL keep out_val and out_err stable while out_valid = 1 && out_ready = 0.
REQ-016 SHALL latch is_32 on the byte transferred in IDLE, and ignore is_32 for the rest of that varint.
REQ-017 SHALL place the payload of byte k (k = 0,1,...) at accumulator bits [7k+6:7k]; payload bits above bit 63 are discarded.
REQ-018 SHALL clear the accumulator and byte counter on each IDLE-state transfer before adding byte 0.
REQ-019 SHALL define the maximum byte count as 5 when the latched is_32 = 1, and 10 when it is 0.
REQ-020 SHALL transition to OUT on the cycle after transferring a byte with bit 7 = 0 (1-cycle latency from final byte to out_valid).
REQ-021 SHALL, when the byte at index max-1 has bit 7 = 1, transition to OUT with out_err = 1 and out_val = 0.
REQ-022 SHALL NOT consume further bytes of an overlong varint; the next transfer starts a new varint.
REQ-023 SHALL, for 64-bit mode, set out_val = (n >> 1) ^ (0 - (n & 1)), where n is the 64-bit accumulator.
REQ-024 SHALL, for 32-bit mode, take m = n[31:0], compute r = (m >> 1) ^ (0 - (m & 1)) in 32 bits, and set out_val = r sign-extended to 64 bits.
REQ-025 SHALL, in 32-bit mode, discard accumulator bits 63:32 without flagging an error.
REQ-026 SHALL return from OUT to IDLE on the output transfer; in_ready rises in the following cycle (no same-cycle accept-through).
REQ-027 SHALL hold FSM state and accumulator while in ACCUM and in_valid = 0 (gaps between bytes allowed).
REQ-028 SHALL ignore in_byte and is_32 whenever no transfer occurs.

Reset
REQ-029 SHALL, while rst = 1, force: state = IDLE, accumulator = 0, byte counter = 0, latched is_32 = 0, out_valid = 0, out_val = 0, out_err = 0, in_ready = 1 after release.
REQ-030 SHALL abort any partially accumulated or pending varint on rst assertion mid-operation, with no output produced for it.

Verification
REQ-031 SHALL pass: is_32 = 1, byte 0x04 -> one cycle later out_valid = 1, out_val = 0x0000000000000002, out_err = 0.
REQ-032 SHALL pass: is_32 = 0, byte 0x03 -> out_val = 0xFFFFFFFFFFFFFFFE (-2).
REQ-033 SHALL pass: is_32 = 0, bytes 0xFE, 0x01 -> out_val = 0x000000000000007F (127).
REQ-034 SHALL pass: is_32 = 0, bytes 0xFF x9 then 0x01 -> out_val = 0x8000000000000000; is_32 = 1, bytes 0xFF x4 then 0x0F -> out_val = 0xFFFFFFFF80000000.
REQ-035 SHALL pass: is_32 = 1, bytes 0x80 x5 -> out_err = 1, out_val = 0, and in_ready = 0 while held; a following 0x02 decodes to 1.
REQ-036 SHALL pass: out_ready held 0 for 3 cycles -> out_val stable and in_ready = 0; rst pulsed after 2 bytes of 0x80 -> no output, and a next byte 0x01 decodes to -1.
